stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//   Sequencing controller for the stopwatch time datapath. It owns the minute/second
//   registers that feed the digit-splitting and 7-segment display stages. It counts
//   on a 1 Hz tick, and supports pause/resume, synchronous clear and per-field manual
//   adjust at 2 Hz. It also supplies a blink phase so the display can flash the field
//   being adjusted.
// PARAMETERS
//   MAX_MIN        59  last minute value before wrap to 0 (must be <= 63)
//   MAX_SEC        59  last second value before wrap to 0 (must be <= 63)
//   START_RUNNING  0   1: leave reset in RUN; 0: leave reset in PAUSED
// PORTS
//   clk        in   1  system clock; all logic on rising edge
//   rst        in   1  asynchronous, active-high reset
//   tick_1hz   in   1  one-clk-wide count strobe
//   tick_2hz   in   1  one-clk-wide adjust/blink strobe
//   pause_pls  in   1  debounced one-clk pulse; toggles RUN/PAUSED
//   clear_pls  in   1  debounced one-clk pulse; zero the time
//   adj        in   1  level; 1 = adjust mode
//   sel        in   1  level; adjust target: 0 = minute, 1 = second
//   minute     out  6  current minutes, 0..MAX_MIN
//   second     out  6  current seconds, 0..MAX_SEC
//   running    out  1  1 when state == RUN
//   adj_mode   out  1  1 when state == ADJUST
//   blink      out  1  blink phase; display blanks selected field when adj_mode & blink
// BEHAVIOUR
//   - All outputs are registered. Reset values: minute=0, second=0, blink=0, adj_mode=0,
//     running=START_RUNNING. State after reset is RUN if START_RUNNING=1, else PAUSED.
//   - States: PAUSED, RUN, ADJUST. A 1-bit resume flag records the RUN/PAUSED state
//     to return to on leaving ADJUST.
//   - Transitions, evaluated every cycle:
//       any state, adj=1                  -> ADJUST (resume flag = prior RUN/PAUSED)
//       ADJUST, adj=0                     -> resume flag state
//       PAUSED, pause_pls (adj=0)         -> RUN
//       RUN,    pause_pls (adj=0)         -> PAUSED
//   - pause_pls is ignored while adj=1 or while in ADJUST. It does not alter the
//     resume flag.
//   - RUN counting: on tick_1hz,
//       second<MAX_SEC                    -> second+1
//       else                              -> second=0, and
//           minute<MAX_MIN                -> minute+1
//           else                          -> minute=0 (full wrap 59:59 -> 00:00)
//   - ADJUST: on tick_2hz the field chosen by sel increments by 1 and wraps
//     MAX->0. There is no carry into the other field. tick_1hz is ignored.
//   - blink toggles on every tick_2hz while in ADJUST. It is forced to 0 outside ADJUST.
//   - Latency: a strobe sampled at edge N is reflected on the outputs after edge N
//     (visible in cycle N+1). State change and count do not apply on the same edge:
//     the count uses the state that was current at that edge.
//   - Priority on the same cycle: clear_pls > adj entry/exit > pause_pls > ticks.
//       clear_pls: minute=second=0, blink=0. State is unchanged (a running watch
//       keeps running from 00:00). Any simultaneous tick is discarded.
//       pause_pls with tick_1hz in RUN: the tick counts, and the state becomes PAUSED.
//       pause_pls with tick_1hz in PAUSED: the tick is discarded, and the state
//       becomes RUN.
//   - Values never exceed MAX_*. Any out-of-range value reached (not possible in
//     normal operation) wraps to 0 on the next increment.
//   - rst asserted mid-count or mid-adjust returns immediately and asynchronously to
//     the reset values.
// TESTING
//   1. rst, START_RUNNING=0; 3 x tick_1hz -> minute=0, second=0, running=0
//   2. pause_pls, then 61 x tick_1hz -> minute=1, second=1, running=1
//   3. Preload to 59:58 in RUN, then 2 x tick_1hz -> 59:59, then 00:00
//   4. adj=1, sel=1 at second=59, then 1 x tick_2hz -> second=0, minute unchanged,
//      blink=1; tick_1hz ignored
//   5. In RUN at 12:34, assert clear_pls and tick_1hz on the same cycle -> 00:00,
//      running=1
//   6. In RUN, adj=1 then adj=0 -> returns to RUN; pause_pls during adj -> no state
//      change

Source files
------------

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bus: strobes/levels into the controller and the registered
// time/status outputs back to the display datapath.
//   i_tick_1hz  count strobe (one clk wide)
//   i_tick_2hz  adjust/blink strobe (one clk wide)
//   i_pause_pls toggles RUN/PAUSED
//   i_clear_pls zeroes the time
//   i_adj       level, 1 = adjust mode
//   i_sel       level, adjust target: 0 = minute, 1 = second
//   o_minute    current minutes
//   o_second    current seconds
//   o_running   1 in RUN
//   o_adj_mode  1 in ADJUST
//   o_blink     blink phase for the field being adjusted
// slave modport = the controller, master modport = whoever drives the controls.
interface stopwatch_ctrl_if;
  logic       i_tick_1hz;
  logic       i_tick_2hz;
  logic       i_pause_pls;
  logic       i_clear_pls;
  logic       i_adj;
  logic       i_sel;
  logic [5:0] o_minute;
  logic [5:0] o_second;
  logic       o_running;
  logic       o_adj_mode;
  logic       o_blink;

  modport slave (
    input  i_tick_1hz, i_tick_2hz, i_pause_pls, i_clear_pls, i_adj, i_sel,
    output o_minute, o_second, o_running, o_adj_mode, o_blink
  );

  modport master (
    output i_tick_1hz, i_tick_2hz, i_pause_pls, i_clear_pls, i_adj, i_sel,
    input  o_minute, o_second, o_running, o_adj_mode, o_blink
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencing controller. Owns the minute/second registers, counts on
// the 1 Hz tick in RUN, supports pause/resume, synchronous clear, and per-field
// adjust on the 2 Hz tick with a blink phase for the adjusted field.
//   i_clk  system clock, rising edge
//   i_rst  asynchronous active-high reset
//   bus    stopwatch_ctrl_if.slave (controls in, time/status out)
// Parameters: MAX_MIN / MAX_SEC last value before wrap (<= 63),
//             START_RUNNING selects RUN (1) or PAUSED (0) out of reset.
module stopwatch_ctrl #(
  parameter int unsigned MAX_MIN       = 59,
  parameter int unsigned MAX_SEC       = 59,
  parameter bit          START_RUNNING = 1'b0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  stopwatch_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_PAUSED = 2'd0,
    ST_RUN    = 2'd1,
    ST_ADJUST = 2'd2
  } state_t;

  localparam logic [5:0] LP_MAX_MIN = 6'(MAX_MIN);
  localparam logic [5:0] LP_MAX_SEC = 6'(MAX_SEC);
  localparam state_t     LP_RST_ST  = START_RUNNING ? ST_RUN : ST_PAUSED;

  state_t     r_state, w_state_nxt;
  logic       r_resume, w_resume_nxt;  // 1 = return to RUN on leaving ADJUST
  logic [5:0] r_minute, w_minute_nxt;
  logic [5:0] r_second, w_second_nxt;
  logic       r_blink, w_blink_nxt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= LP_RST_ST;
      r_resume <= START_RUNNING;
      r_minute <= '0;
      r_second <= '0;
      r_blink  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_resume <= w_resume_nxt;
      r_minute <= w_minute_nxt;
      r_second <= w_second_nxt;
      r_blink  <= w_blink_nxt;
    end
  end

  // Next state. Clear holds the state; adj dominates pause.
  always_comb begin
    w_state_nxt  = r_state;
    w_resume_nxt = r_resume;
    if (bus.i_clear_pls) begin
      w_state_nxt = r_state;
    end else if (bus.i_adj) begin
      if (r_state != ST_ADJUST) w_resume_nxt = (r_state == ST_RUN);
      w_state_nxt = ST_ADJUST;
    end else if (r_state == ST_ADJUST) begin
      w_state_nxt = r_resume ? ST_RUN : ST_PAUSED;
    end else if (bus.i_pause_pls) begin
      w_state_nxt = (r_state == ST_RUN) ? ST_PAUSED : ST_RUN;
    end
  end

  // Datapath acts on the state current at this edge, not the next one, so a
  // pause with a tick in RUN still counts and a resume with a tick does not.
  // '>=' comparisons make any out-of-range value wrap to 0 on the next step.
  always_comb begin
    w_minute_nxt = r_minute;
    w_second_nxt = r_second;
    w_blink_nxt  = r_blink;
    if (bus.i_clear_pls) begin
      w_minute_nxt = '0;
      w_second_nxt = '0;
      w_blink_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (bus.i_tick_1hz) begin
            if (r_second >= LP_MAX_SEC) begin
              w_second_nxt = '0;
              w_minute_nxt = (r_minute >= LP_MAX_MIN) ? '0 : r_minute + 6'd1;
            end else begin
              w_second_nxt = r_second + 6'd1;
            end
          end
        end
        ST_ADJUST: begin
          if (bus.i_tick_2hz) begin
            w_blink_nxt = ~r_blink;
            if (bus.i_sel)
              w_second_nxt = (r_second >= LP_MAX_SEC) ? '0 : r_second + 6'd1;
            else
              w_minute_nxt = (r_minute >= LP_MAX_MIN) ? '0 : r_minute + 6'd1;
          end
        end
        default: ;
      endcase
      if (w_state_nxt != ST_ADJUST) w_blink_nxt = 1'b0;
    end
  end

  assign bus.o_minute   = r_minute;
  assign bus.o_second   = r_second;
  assign bus.o_running  = (r_state == ST_RUN);
  assign bus.o_adj_mode = (r_state == ST_ADJUST);
  assign bus.o_blink    = r_blink;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl with default parameters
// (59/59, starts PAUSED).
module tb_stopwatch_ctrl;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;

  stopwatch_ctrl_if sw ();

  stopwatch_ctrl #(
    .MAX_MIN      (59),
    .MAX_SEC      (59),
    .START_RUNNING(1'b0)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (sw)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Hold tick_1hz high for n edges: n counts in RUN.
  task automatic ticks(input int unsigned n);
    sw.i_tick_1hz = 1'b1;
    repeat (n) step();
    sw.i_tick_1hz = 1'b0;
  endtask

  task automatic chk_time(input string tag, input int m, input int s);
    chk({tag, "_min"}, int'(sw.o_minute), m);
    chk({tag, "_sec"}, int'(sw.o_second), s);
  endtask

  initial begin
    sw.i_tick_1hz  = 1'b0;
    sw.i_tick_2hz  = 1'b0;
    sw.i_pause_pls = 1'b0;
    sw.i_clear_pls = 1'b0;
    sw.i_adj       = 1'b0;
    sw.i_sel       = 1'b0;

    // Reset state
    repeat (2) step();
    chk_time("rst", 0, 0);
    chk("rst_running", int'(sw.o_running), 0);
    chk("rst_adj", int'(sw.o_adj_mode), 0);
    chk("rst_blink", int'(sw.o_blink), 0);
    i_rst = 1'b0;
    step();

    // 1: ticks while PAUSED do nothing
    repeat (3) begin
      sw.i_tick_1hz = 1'b1; step();
      sw.i_tick_1hz = 1'b0; step();
    end
    chk_time("t1", 0, 0);
    chk("t1_running", int'(sw.o_running), 0);

    // 2: resume, 61 ticks -> 01:01
    sw.i_pause_pls = 1'b1; step();
    sw.i_pause_pls = 1'b0;
    chk("t2_running", int'(sw.o_running), 1);
    repeat (61) begin
      sw.i_tick_1hz = 1'b1; step();
      sw.i_tick_1hz = 1'b0; step();
    end
    chk_time("t2", 1, 1);

    // 3: 61 s -> 3598 s (59:58), then full wrap
    ticks(3537);
    chk_time("t3_pre", 59, 58);
    ticks(1);
    chk_time("t3_5959", 59, 59);
    ticks(1);
    chk_time("t3_wrap", 0, 0);

    // 4: adjust seconds at 00:59
    ticks(59);
    chk_time("t4_pre", 0, 59);
    sw.i_adj = 1'b1; sw.i_sel = 1'b1; step();
    chk("t4_adj", int'(sw.o_adj_mode), 1);
    chk("t4_run0", int'(sw.o_running), 0);
    chk("t4_blink0", int'(sw.o_blink), 0);
    sw.i_tick_2hz = 1'b1; step();
    sw.i_tick_2hz = 1'b0;
    chk_time("t4_adjsec", 0, 0);
    chk("t4_blink1", int'(sw.o_blink), 1);
    ticks(1);
    chk_time("t4_tick_ign", 0, 0);
    sw.i_sel = 1'b0;
    sw.i_tick_2hz = 1'b1; step();
    sw.i_tick_2hz = 1'b0;
    chk_time("t4_adjmin", 1, 0);
    chk("t4_blink2", int'(sw.o_blink), 0);
    sw.i_adj = 1'b0; step();
    chk("t4_exit_run", int'(sw.o_running), 1);
    chk("t4_exit_adj", int'(sw.o_adj_mode), 0);

    // 5: clear beats a simultaneous tick; keeps running
    ticks(694);
    chk_time("t5_pre", 12, 34);
    sw.i_clear_pls = 1'b1; sw.i_tick_1hz = 1'b1; step();
    sw.i_clear_pls = 1'b0; sw.i_tick_1hz = 1'b0;
    chk_time("t5_clr", 0, 0);
    chk("t5_running", int'(sw.o_running), 1);

    // 6: pause ignored during adj; exit back to RUN
    sw.i_adj = 1'b1; step();
    chk("t6_adj", int'(sw.o_adj_mode), 1);
    sw.i_pause_pls = 1'b1; step();
    sw.i_pause_pls = 1'b0;
    chk("t6_pause_ign", int'(sw.o_adj_mode), 1);
    sw.i_adj = 1'b0; step();
    chk("t6_back_run", int'(sw.o_running), 1);
    chk_time("t6_time", 0, 0);

    // pause+tick in RUN counts; pause+tick in PAUSED is discarded
    sw.i_pause_pls = 1'b1; sw.i_tick_1hz = 1'b1; step();
    chk_time("pt_run", 0, 1);
    chk("pt_run_state", int'(sw.o_running), 0);
    step();
    sw.i_pause_pls = 1'b0; sw.i_tick_1hz = 1'b0;
    chk_time("pt_paused", 0, 1);
    chk("pt_paused_state", int'(sw.o_running), 1);

    // asynchronous reset mid-count
    ticks(5);
    chk_time("ar_pre", 0, 6);
    i_rst = 1'b1;
    #1;
    chk_time("ar", 0, 0);
    chk("ar_running", int'(sw.o_running), 0);
    step();
    i_rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
